// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_pkg
// Description : Shared operation codes, transfer-engine state encoding and
//               RPL storage sizing for the Chip-8 memory transfer engine.
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_pkg;

  localparam logic [2:0] XFER_OP_STORE    = 3'd0;
  localparam logic [2:0] XFER_OP_LOAD     = 3'd1;
  localparam logic [2:0] XFER_OP_BCD      = 3'd2;
  localparam logic [2:0] XFER_OP_RPL_SAVE = 3'd3;
  localparam logic [2:0] XFER_OP_RPL_LOAD = 3'd4;

  typedef logic [3:0] xfer_state_t;

  localparam xfer_state_t XFER_ST_IDLE     = 4'd0;
  localparam xfer_state_t XFER_ST_WR       = 4'd1;
  localparam xfer_state_t XFER_ST_RD_ISSUE = 4'd2;
  localparam xfer_state_t XFER_ST_RD_WAIT  = 4'd3;
  localparam xfer_state_t XFER_ST_RD_CAPT  = 4'd4;
  localparam xfer_state_t XFER_ST_BCD0     = 4'd5;
  localparam xfer_state_t XFER_ST_BCD1     = 4'd6;
  localparam xfer_state_t XFER_ST_BCD2     = 4'd7;
  localparam xfer_state_t XFER_ST_RPL      = 4'd8;
  localparam xfer_state_t XFER_ST_FIN      = 4'd9;

  localparam int RPL_DEPTH = 8;
  localparam int RPL_IDX_W = 3;

endpackage
`default_nettype wire

// File: rtl/chip8_mem_xfer_if.sv
`default_nettype none
// ============================================================================
// Module      : chip8_mem_xfer_if
// Description : CPU-side command, register-file and RAM bus of the Chip-8
//               transfer engine. slave = engine view, master = CPU/env view.
// Revision    : 1.0 - initial release
// ============================================================================
interface chip8_mem_xfer_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 12
);
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic              start;
  logic [2:0]        op;
  logic [IDX_W-1:0]  first_reg;
  logic [IDX_W-1:0]  last_reg;
  logic [ADDR_W-1:0] base_addr;
  logic              inc_i;
  logic              busy;
  logic              done;
  logic              err;
  logic              i_update;
  logic [ADDR_W-1:0] i_new;
  logic [IDX_W-1:0]  reg_idx;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic              ram_en;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  start, op, first_reg, last_reg, base_addr, inc_i, reg_rdata, ram_rdata,
    output busy, done, err, i_update, i_new, reg_idx, reg_we, reg_wdata,
           ram_en, ram_wr, ram_addr, ram_wdata
  );

  modport master (
    output start, op, first_reg, last_reg, base_addr, inc_i, reg_rdata, ram_rdata,
    input  busy, done, err, i_update, i_new, reg_idx, reg_we, reg_wdata,
           ram_en, ram_wr, ram_addr, ram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/chip8_xfer_bcd.sv
`default_nettype none
// ============================================================================
// Module      : chip8_xfer_bcd
// Description : Combinational split of a register value into hundreds, tens
//               and ones digits.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_xfer_bcd #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_value,
  output logic [DATA_W-1:0] o_hundreds,
  output logic [DATA_W-1:0] o_tens,
  output logic [DATA_W-1:0] o_ones
);
  // Widen narrow data so the constant divisors are representable.
  localparam int VW = (DATA_W < 8) ? 8 : DATA_W;

  logic [VW-1:0] w_value;
  logic [VW-1:0] w_tens_all;

  assign w_value    = VW'(i_value);
  assign w_tens_all = w_value / VW'(10);
  assign o_hundreds = DATA_W'(w_value / VW'(100));
  assign o_tens     = DATA_W'(w_tens_all % VW'(10));
  assign o_ones     = DATA_W'(w_value % VW'(10));

endmodule
`default_nettype wire

// File: rtl/chip8_mem_xfer.sv
`default_nettype none
// ============================================================================
// Module      : chip8_mem_xfer
// Description : Register/RAM block-transfer engine (Fx55/Fx65/Fx33, 5XY2/5XY3)
//               with configurable RAM latency. Define CHIP8_XFER_RPL_EN to
//               build the RPL flag storage and enable ops RPL_SAVE/RPL_LOAD.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_mem_xfer
  import chip8_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 16,
  parameter int ADDR_W  = 12,
  parameter int RAM_LAT = 1
) (
  input  logic            clk,
  input  logic            res_n,
  chip8_mem_xfer_if.slave bus
);
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CNT_W = IDX_W + 1;

  xfer_state_t       r_state;
  xfer_state_t       w_next;

  logic [2:0]        r_op;
  logic [IDX_W-1:0]  r_idx;
  logic              r_dir;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_k;
  logic [ADDR_W-1:0] r_base;
  logic              r_inc;
  logic              r_err;
  logic [1:0]        r_lat;

  logic              w_accept;
  logic              w_last;
  logic              w_wait_done;
  logic              w_rpl_op;
  logic              w_start_err;
  logic              w_up;
  logic [IDX_W-1:0]  w_span;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_hund;
  logic [DATA_W-1:0] w_tens;
  logic [DATA_W-1:0] w_ones;
  logic [DATA_W-1:0] w_rpl_rdata;

  assign w_accept    = (r_state == XFER_ST_IDLE) && bus.start;
  assign w_last      = (r_k == (r_count - CNT_W'(1)));
  assign w_wait_done = (r_lat == 2'(RAM_LAT - 2));
  assign w_rpl_op    = (bus.op == XFER_OP_RPL_SAVE) || (bus.op == XFER_OP_RPL_LOAD);
  assign w_up        = (bus.last_reg >= bus.first_reg);
  assign w_span      = w_up ? (bus.last_reg - bus.first_reg) : (bus.first_reg - bus.last_reg);
  assign w_count     = CNT_W'(w_span) + CNT_W'(1);
  assign w_addr      = r_base + ADDR_W'(r_k);

`ifdef CHIP8_XFER_RPL_EN
  assign w_start_err = (bus.op > XFER_OP_RPL_LOAD) ||
                       (w_rpl_op && (int'(bus.last_reg) >= RPL_DEPTH));

  logic [DATA_W-1:0] r_rpl [RPL_DEPTH];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < RPL_DEPTH; i++) begin
        r_rpl[i] <= '0;
      end
    end else if ((r_state == XFER_ST_RPL) && (r_op == XFER_OP_RPL_SAVE)) begin
      r_rpl[r_idx[RPL_IDX_W-1:0]] <= bus.reg_rdata;
    end
  end

  assign w_rpl_rdata = r_rpl[r_idx[RPL_IDX_W-1:0]];
`else
  assign w_start_err = (bus.op > XFER_OP_BCD);
  assign w_rpl_rdata = '0;
`endif

  chip8_xfer_bcd #(
    .DATA_W     (DATA_W)
  ) u_bcd (
    .i_value    (bus.reg_rdata),
    .o_hundreds (w_hund),
    .o_tens     (w_tens),
    .o_ones     (w_ones)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= XFER_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      XFER_ST_IDLE: begin
        if (bus.start) begin
          if (w_start_err) begin
            w_next = XFER_ST_FIN;
          end else begin
            case (bus.op)
              XFER_OP_STORE: w_next = XFER_ST_WR;
              XFER_OP_LOAD:  w_next = XFER_ST_RD_ISSUE;
              XFER_OP_BCD:   w_next = XFER_ST_BCD0;
              default:       w_next = XFER_ST_RPL;
            endcase
          end
        end
      end
      XFER_ST_WR:       w_next = w_last ? XFER_ST_FIN : XFER_ST_WR;
      XFER_ST_RD_ISSUE: w_next = (RAM_LAT > 1) ? XFER_ST_RD_WAIT : XFER_ST_RD_CAPT;
      XFER_ST_RD_WAIT:  w_next = w_wait_done ? XFER_ST_RD_CAPT : XFER_ST_RD_WAIT;
      XFER_ST_RD_CAPT:  w_next = w_last ? XFER_ST_FIN : XFER_ST_RD_ISSUE;
      XFER_ST_BCD0:     w_next = XFER_ST_BCD1;
      XFER_ST_BCD1:     w_next = XFER_ST_BCD2;
      XFER_ST_BCD2:     w_next = XFER_ST_FIN;
      XFER_ST_RPL:      w_next = w_last ? XFER_ST_FIN : XFER_ST_RPL;
      XFER_ST_FIN:      w_next = XFER_ST_IDLE;
      default:          w_next = XFER_ST_IDLE;
    endcase
  end

  // Operands are captured once at accept; the CPU may change them while busy.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_op    <= '0;
      r_idx   <= '0;
      r_dir   <= 1'b0;
      r_count <= '0;
      r_k     <= '0;
      r_base  <= '0;
      r_inc   <= 1'b0;
      r_err   <= 1'b0;
      r_lat   <= '0;
    end else if (w_accept) begin
      r_op   <= bus.op;
      r_base <= bus.base_addr;
      r_inc  <= bus.inc_i;
      r_err  <= w_start_err;
      r_k    <= '0;
      r_lat  <= '0;
      if (w_rpl_op) begin
        r_idx   <= '0;
        r_dir   <= 1'b1;
        r_count <= CNT_W'(bus.last_reg) + CNT_W'(1);
      end else begin
        r_idx   <= bus.first_reg;
        r_dir   <= w_up;
        r_count <= w_count;
      end
    end else begin
      case (r_state)
        XFER_ST_WR, XFER_ST_RD_CAPT, XFER_ST_RPL: begin
          if (!w_last) begin
            r_k   <= r_k + CNT_W'(1);
            r_idx <= r_dir ? (r_idx + IDX_W'(1)) : (r_idx - IDX_W'(1));
          end
        end
        XFER_ST_RD_ISSUE: r_lat <= '0;
        XFER_ST_RD_WAIT:  r_lat <= r_lat + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (r_state != XFER_ST_IDLE);
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.i_update  = 1'b0;
    bus.i_new     = '0;
    bus.reg_idx   = '0;
    bus.reg_we    = 1'b0;
    bus.reg_wdata = '0;
    bus.ram_en    = 1'b0;
    bus.ram_wr    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    case (r_state)
      XFER_ST_WR: begin
        bus.reg_idx   = r_idx;
        bus.ram_en    = 1'b1;
        bus.ram_wr    = 1'b1;
        bus.ram_addr  = w_addr;
        bus.ram_wdata = bus.reg_rdata;
      end
      XFER_ST_RD_ISSUE: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = w_addr;
      end
      XFER_ST_RD_CAPT: begin
        bus.reg_idx   = r_idx;
        bus.reg_we    = 1'b1;
        bus.reg_wdata = bus.ram_rdata;
      end
      XFER_ST_BCD0: begin
        bus.reg_idx   = r_idx;
        bus.ram_en    = 1'b1;
        bus.ram_wr    = 1'b1;
        bus.ram_addr  = r_base;
        bus.ram_wdata = w_hund;
      end
      XFER_ST_BCD1: begin
        bus.reg_idx   = r_idx;
        bus.ram_en    = 1'b1;
        bus.ram_wr    = 1'b1;
        bus.ram_addr  = r_base + ADDR_W'(1);
        bus.ram_wdata = w_tens;
      end
      XFER_ST_BCD2: begin
        bus.reg_idx   = r_idx;
        bus.ram_en    = 1'b1;
        bus.ram_wr    = 1'b1;
        bus.ram_addr  = r_base + ADDR_W'(2);
        bus.ram_wdata = w_ones;
      end
      XFER_ST_RPL: begin
        bus.reg_idx = r_idx;
        if (r_op == XFER_OP_RPL_LOAD) begin
          bus.reg_we    = 1'b1;
          bus.reg_wdata = w_rpl_rdata;
        end
      end
      XFER_ST_FIN: begin
        bus.done = 1'b1;
        bus.err  = r_err;
        if (!r_err && r_inc && ((r_op == XFER_OP_STORE) || (r_op == XFER_OP_LOAD))) begin
          bus.i_update = 1'b1;
          bus.i_new    = r_base + ADDR_W'(r_count);
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_mem_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_mem_xfer
// Description : Directed vector bench for chip8_mem_xfer with a register-file
//               and RAM_LAT=2 RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_mem_xfer;
  import chip8_pkg::*;

  localparam int DW  = 8;
  localparam int NR  = 16;
  localparam int AW  = 12;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  chip8_mem_xfer_if #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) bus ();

  chip8_mem_xfer #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .RAM_LAT(LAT)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  logic [7:0]  regs [16];
  logic [7:0]  ram  [4096];
  logic [7:0]  rdata = '0;
  logic        p1_v  = 1'b0;
  logic [11:0] p1_a  = '0;
  int          en_cnt = 0;
  int          we_cnt = 0;
  int          wr_cnt = 0;

  logic        bd_reg_we = 1'b0;
  logic        bd_ram_we = 1'b0;
  logic        bd_clr    = 1'b0;
  logic [11:0] bd_addr   = '0;
  logic [7:0]  bd_val    = '0;

  assign bus.reg_rdata = regs[bus.reg_idx];
  assign bus.ram_rdata = rdata;

  always @(posedge clk) begin
    if (bd_reg_we)    regs[bd_addr[3:0]] <= bd_val;
    else if (bus.reg_we) regs[bus.reg_idx] <= bus.reg_wdata;
    if (bd_ram_we)    ram[bd_addr] <= bd_val;
    else if (bus.ram_en && bus.ram_wr) ram[bus.ram_addr] <= bus.ram_wdata;
    p1_v <= bus.ram_en && !bus.ram_wr;
    p1_a <= bus.ram_addr;
    if (p1_v) rdata <= ram[p1_a];
    if (bd_clr) begin
      en_cnt <= 0;
      we_cnt <= 0;
    end else begin
      if (bus.ram_en) en_cnt <= en_cnt + 1;
      if (bus.reg_we) we_cnt <= we_cnt + 1;
    end
    if (bus.ram_en && bus.ram_wr) wr_cnt <= wr_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int idx, input logic [7:0] val);
    bd_addr = 12'(idx); bd_val = val; bd_reg_we = 1'b1;
    tick();
    bd_reg_we = 1'b0;
  endtask

  task automatic set_ram(input logic [11:0] addr, input logic [7:0] val);
    bd_addr = addr; bd_val = val; bd_ram_we = 1'b1;
    tick();
    bd_ram_we = 1'b0;
  endtask

  task automatic init_regs();
    for (int r = 0; r < 16; r++) set_reg(r, 8'((r + 1) * 8'h11));
  endtask

  task automatic clr_cnt();
    bd_clr = 1'b1;
    tick();
    bd_clr = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [3:0] first, input logic [3:0] last,
                        input logic [11:0] base, input logic inc,
                        output int lat, output logic busy1, output logic e,
                        output logic iu, output logic [11:0] inew);
    bus.op = op; bus.first_reg = first; bus.last_reg = last;
    bus.base_addr = base; bus.inc_i = inc; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy1 = bus.busy;
    lat = 1;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
    e = bus.err; iu = bus.i_update; inew = bus.i_new;
    tick();
    check("done_pulse", 32'(bus.done), 32'd0);
    check("busy_clear", 32'(bus.busy), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  first;
    logic [3:0]  last;
    logic [11:0] base;
    logic        inc;
    int          set_idx;
    logic [7:0]  set_val;
    int          lat;
    logic        err;
    logic        iupd;
    logic [11:0] inew;
    logic        quiet;
    int          nchk;
    logic        chk_ram;
    int          chk_a [4];
    logic [7:0]  chk_v [4];
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] op, input logic [3:0] first, input logic [3:0] last,
                         input logic [11:0] base, input logic inc, input int set_idx,
                         input logic [7:0] set_val, input int lat, input logic err,
                         input logic iupd, input logic [11:0] inew, input logic quiet,
                         input int nchk, input logic chk_ram,
                         input int a0, input int a1, input int a2, input int a3,
                         input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] v2, input logic [7:0] v3);
    vec_t v;
    v.op = op; v.first = first; v.last = last; v.base = base; v.inc = inc;
    v.set_idx = set_idx; v.set_val = set_val; v.lat = lat; v.err = err;
    v.iupd = iupd; v.inew = inew; v.quiet = quiet; v.nchk = nchk; v.chk_ram = chk_ram;
    v.chk_a[0] = a0; v.chk_a[1] = a1; v.chk_a[2] = a2; v.chk_a[3] = a3;
    v.chk_v[0] = v0; v.chk_v[1] = v1; v.chk_v[2] = v2; v.chk_v[3] = v3;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t        v;
    int          lat;
    logic        busy1, e, iu;
    logic [11:0] inew;
    logic [7:0]  act;
    int          pre_wr;

    bus.start = 1'b0; bus.op = '0; bus.first_reg = '0; bus.last_reg = '0;
    bus.base_addr = '0; bus.inc_i = 1'b0;

    // Register values default to (r+1)*0x11 before every vector.
    add_vec(XFER_OP_STORE, 4'd0, 4'd3, 12'h300, 1'b1, -1, 8'h00, 5, 1'b0, 1'b1, 12'h304, 1'b0,
            4, 1'b1, 'h300, 'h301, 'h302, 'h303, 8'h11, 8'h22, 8'h33, 8'h44);
    add_vec(XFER_OP_LOAD, 4'd5, 4'd2, 12'h400, 1'b0, -1, 8'h00, 13, 1'b0, 1'b0, 12'h000, 1'b0,
            4, 1'b0, 5, 4, 3, 2, 8'h0A, 8'h0B, 8'h0C, 8'h0D);
    add_vec(XFER_OP_BCD, 4'd7, 4'd0, 12'hFFF, 1'b1, 7, 8'd255, 4, 1'b0, 1'b0, 12'h000, 1'b0,
            3, 1'b1, 'hFFF, 'h000, 'h001, 0, 8'd2, 8'd5, 8'd5, 8'd0);
    add_vec(XFER_OP_STORE, 4'd9, 4'd9, 12'hFFF, 1'b1, -1, 8'h00, 2, 1'b0, 1'b1, 12'h000, 1'b0,
            1, 1'b1, 'hFFF, 0, 0, 0, 8'hAA, 8'h00, 8'h00, 8'h00);
    add_vec(XFER_OP_LOAD, 4'd0, 4'd0, 12'h000, 1'b1, -1, 8'h00, 4, 1'b0, 1'b1, 12'h001, 1'b0,
            1, 1'b0, 0, 0, 0, 0, 8'd5, 8'h00, 8'h00, 8'h00);
    add_vec(XFER_OP_LOAD, 4'd14, 4'd15, 12'hFFF, 1'b1, -1, 8'h00, 7, 1'b0, 1'b1, 12'h001, 1'b0,
            2, 1'b0, 14, 15, 0, 0, 8'hAA, 8'd5, 8'h00, 8'h00);
    add_vec(XFER_OP_STORE, 4'd3, 4'd1, 12'h310, 1'b1, -1, 8'h00, 4, 1'b0, 1'b1, 12'h313, 1'b0,
            3, 1'b1, 'h310, 'h311, 'h312, 0, 8'h44, 8'h33, 8'h22, 8'h00);
    add_vec(3'd6, 4'd0, 4'd3, 12'h200, 1'b1, -1, 8'h00, 1, 1'b1, 1'b0, 12'h000, 1'b1,
            0, 1'b0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
`ifndef CHIP8_XFER_RPL_EN
    add_vec(XFER_OP_RPL_SAVE, 4'd0, 4'd7, 12'h200, 1'b0, -1, 8'h00, 1, 1'b1, 1'b0, 12'h000, 1'b1,
            0, 1'b0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(XFER_OP_RPL_LOAD, 4'd0, 4'd7, 12'h200, 1'b0, -1, 8'h00, 1, 1'b1, 1'b0, 12'h000, 1'b1,
            0, 1'b0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
`endif

    // Reset state
    tick(); tick();
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_err",      32'(bus.err),      32'd0);
    check("rst_ram_en",   32'(bus.ram_en),   32'd0);
    check("rst_reg_we",   32'(bus.reg_we),   32'd0);
    check("rst_i_update", 32'(bus.i_update), 32'd0);
    res_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) set_ram(12'h400 + 12'(i), 8'h0A + 8'(i));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      init_regs();
      if (v.set_idx >= 0) set_reg(v.set_idx, v.set_val);
      clr_cnt();
      run_op(v.op, v.first, v.last, v.base, v.inc, lat, busy1, e, iu, inew);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d_busy", i), 32'(busy1), 32'd1);
      check($sformatf("v%0d_err", i), 32'(e), 32'(v.err));
      check($sformatf("v%0d_i_update", i), 32'(iu), 32'(v.iupd));
      if (v.iupd) check($sformatf("v%0d_i_new", i), 32'(inew), 32'(v.inew));
      if (v.quiet) begin
        check($sformatf("v%0d_no_ram", i), 32'(en_cnt), 32'd0);
        check($sformatf("v%0d_no_reg", i), 32'(we_cnt), 32'd0);
      end
      for (int c = 0; c < v.nchk; c++) begin
        act = v.chk_ram ? ram[12'(v.chk_a[c])] : regs[4'(v.chk_a[c])];
        check($sformatf("v%0d_data%0d", i, c), 32'(act), 32'(v.chk_v[c]));
      end
    end

    // Asynchronous reset in the second write cycle of a 16-register STORE
    init_regs();
    set_ram(12'h501, 8'hEE);
    bus.op = XFER_OP_STORE; bus.first_reg = 4'd0; bus.last_reg = 4'd15;
    bus.base_addr = 12'h500; bus.inc_i = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2 res_n = 1'b0;
    #1;
    check("arst_busy",   32'(bus.busy),   32'd0);
    check("arst_ram_en", 32'(bus.ram_en), 32'd0);
    check("arst_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("arst_done",   32'(bus.done),   32'd0);
    pre_wr = wr_cnt;
    tick(); tick(); tick();
    check("arst_no_writes", 32'(wr_cnt), 32'(pre_wr));
    check("arst_ram500", 32'(ram[12'h500]), 32'h11);
    check("arst_ram501", 32'(ram[12'h501]), 32'hEE);
    res_n = 1'b1;
    tick();
    run_op(XFER_OP_STORE, 4'd2, 4'd3, 12'h600, 1'b1, lat, busy1, e, iu, inew);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_i_new",   32'(inew), 32'h602);
    check("post_rst_ram600",  32'(ram[12'h600]), 32'h33);
    check("post_rst_ram601",  32'(ram[12'h601]), 32'h44);

    // start held while busy must not restart or alter the running op
    init_regs();
    bus.op = XFER_OP_STORE; bus.first_reg = 4'd0; bus.last_reg = 4'd1;
    bus.base_addr = 12'h700; bus.inc_i = 1'b1; bus.start = 1'b1;
    tick();
    bus.op = XFER_OP_LOAD; bus.first_reg = 4'd5; bus.last_reg = 4'd9;
    bus.base_addr = 12'h123; bus.inc_i = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check("busy_start_latency", 32'(lat), 32'd3);
    check("busy_start_i_upd",   32'(bus.i_update), 32'd1);
    check("busy_start_i_new",   32'(bus.i_new), 32'h702);
    tick();
    check("busy_start_idle",    32'(bus.busy), 32'd0);
    check("busy_start_ram700",  32'(ram[12'h700]), 32'h11);
    check("busy_start_ram701",  32'(ram[12'h701]), 32'h22);

`ifdef CHIP8_XFER_RPL_EN
    init_regs();
    run_op(XFER_OP_RPL_SAVE, 4'd0, 4'd7, 12'h000, 1'b1, lat, busy1, e, iu, inew);
    check("rpl_save_latency", 32'(lat), 32'd9);
    check("rpl_save_err", 32'(e), 32'd0);
    for (int r = 0; r < 8; r++) set_reg(r, 8'h00);
    clr_cnt();
    run_op(XFER_OP_RPL_LOAD, 4'd0, 4'd7, 12'h000, 1'b1, lat, busy1, e, iu, inew);
    check("rpl_load_latency", 32'(lat), 32'd9);
    check("rpl_load_i_upd", 32'(iu), 32'd0);
    check("rpl_no_ram", 32'(en_cnt), 32'd0);
    for (int r = 0; r < 8; r++) begin
      check($sformatf("rpl_v%0d", r), 32'(regs[r]), 32'(8'((r + 1) * 8'h11)));
    end
    run_op(XFER_OP_RPL_SAVE, 4'd0, 4'd8, 12'h000, 1'b0, lat, busy1, e, iu, inew);
    check("rpl_range_err", 32'(e), 32'd1);
    check("rpl_range_latency", 32'(lat), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
